// File: rtl/feed_skew_d_pkg.sv
// Shared types for the D-side feeder: one lane beat and the lane slicing helper.
// Pure declarations, no logic or timing of its own.
package feed_skew_d_pkg;

  localparam int LANE_DATA_W = 8;

  typedef struct packed {
    logic [LANE_DATA_W-1:0] data;
    logic                   valid;
    logic                   last;
  } lane_beat_t;

  // Low bit of lane 'lane' inside a flat lanes*data_w bus.
  function automatic int lane_lo(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/feed_skew_d_if.sv
// Bus between the D buffer / address generator side and the systolic-array rows.
// master drives mask, read data and burst length; slave returns the skewed lanes.
interface feed_skew_d_if #(
  parameter int N1           = 4,
  parameter int DATA_W       = 8,
  parameter int MATRIXSIZE_W = 16
) ();

  logic [MATRIXSIZE_W-1:0] M3;
  logic [N1-1:0]           activate_D;
  logic [DATA_W-1:0]       rd_data_D;
  logic [N1*DATA_W-1:0]    sys_data_D;
  logic [N1-1:0]           sys_valid_D;
  logic [N1-1:0]           row_last_D;

  modport master (
    output M3, activate_D, rd_data_D,
    input  sys_data_D, sys_valid_D, row_last_D
  );

  modport slave (
    input  M3, activate_D, rd_data_D,
    output sys_data_D, sys_valid_D, row_last_D
  );

endinterface

// File: rtl/feed_skew_d_skew_delay_line.sv
// DEPTH-stage register chain with synchronous clear; DEPTH=0 is a wire.
// Latency DEPTH cycles, no backpressure.
module feed_skew_d_skew_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = clk ^ rst;
    assign dout      = din;
  end else begin : g_regs
    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/feed_skew_d.sv
// Steers D read data to the masked array rows, counts burst elements and applies triangular skew.
// Lane r latency RD_LAT+1+r from activate_D; full throughput, no backpressure.
module feed_skew_d
  import feed_skew_d_pkg::*;
#(
  parameter int N1           = 4,
  parameter int DATA_W       = LANE_DATA_W,
  parameter int RD_LAT       = 1,
  parameter int MATRIXSIZE_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  feed_skew_d_if.slave  bus
);

  if (DATA_W != LANE_DATA_W) begin : g_bad_data_w
    $error("feed_skew_d: DATA_W must equal feed_skew_d_pkg::LANE_DATA_W");
  end

  logic [N1-1:0]           act_al;
  lane_beat_t              cap   [N1];
  lane_beat_t              skew  [N1];
  logic [MATRIXSIZE_W-1:0] cnt   [N1];
  logic [MATRIXSIZE_W-1:0] cnt_end;

  // Mask waits out the buffer read latency so it lines up with rd_data_D.
  feed_skew_d_skew_delay_line #(
    .W     (N1),
    .DEPTH (RD_LAT)
  ) u_act_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.activate_D),
    .dout (act_al)
  );

  assign cnt_end = bus.M3 - MATRIXSIZE_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N1; r++) begin
        cap[r] <= '0;
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < N1; r++) begin
        cap[r].valid <= act_al[r];
        cap[r].data  <= act_al[r] ? bus.rd_data_D : '0;
        cap[r].last  <= 1'b0;
        if (act_al[r]) begin
          if (cnt[r] == cnt_end) begin
            cap[r].last <= 1'b1;
            cnt[r]      <= '0;
          end else begin
            cnt[r]      <= cnt[r] + MATRIXSIZE_W'(1);
          end
        end
      end
    end
  end

  for (genvar r = 0; r < N1; r++) begin : g_lane
    // Lane r lags lane 0 by r cycles to form the diagonal wavefront.
    feed_skew_d_skew_delay_line #(
      .W     ($bits(lane_beat_t)),
      .DEPTH (r)
    ) u_skew (
      .clk  (clk),
      .rst  (rst),
      .din  (cap[r]),
      .dout (skew[r])
    );

    assign bus.sys_data_D[lane_lo(r, DATA_W) +: DATA_W] = skew[r].data;
    assign bus.sys_valid_D[r]                           = skew[r].valid;
    assign bus.row_last_D[r]                            = skew[r].last;
  end

endmodule

// File: tb/tb_feed_skew_d.sv
// Drives two feeders (RD_LAT 1 and 3) with identical stimulus and checks every cycle
// against a beat-schedule reference model plus directed constant checks.
module tb_feed_skew_d;

  localparam int N1    = 4;
  localparam int DW    = 8;
  localparam int MW    = 16;
  localparam int NSTEP = 1024;
  localparam int M3V   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  feed_skew_d_if #(.N1(N1), .DATA_W(DW), .MATRIXSIZE_W(MW)) bus1 ();
  feed_skew_d_if #(.N1(N1), .DATA_W(DW), .MATRIXSIZE_W(MW)) bus3 ();

  feed_skew_d #(.N1(N1), .DATA_W(DW), .RD_LAT(1), .MATRIXSIZE_W(MW)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );
  feed_skew_d #(.N1(N1), .DATA_W(DW), .RD_LAT(3), .MATRIXSIZE_W(MW)) u_dut3 (
    .clk (clk), .rst (rst), .bus (bus3.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_rst = -1;
  int lat [2] = '{1, 3};

  bit [N1-1:0] mask_hist [NSTEP];
  int          cnt_m     [2][N1];
  bit [DW-1:0] exp_d     [2][NSTEP][N1];
  bit          exp_v     [2][NSTEP][N1];
  bit          exp_l     [2][NSTEP][N1];

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
    end
  endtask

  // Reference: a beat leaves lane r RD_LAT+1+r steps after its mask, unless a reset intervened.
  task automatic model(input bit r, input bit [N1-1:0] m, input bit [DW-1:0] d);
    if (r) begin
      last_rst = cyc;
      for (int u = 0; u < 2; u++) begin
        for (int l = 0; l < N1; l++) cnt_m[u][l] = 0;
        for (int c = cyc + 1; c < NSTEP; c++)
          for (int l = 0; l < N1; l++) begin
            exp_v[u][c][l] = 1'b0;
            exp_d[u][c][l] = '0;
            exp_l[u][c][l] = 1'b0;
          end
      end
    end else begin
      mask_hist[cyc] = m;
      for (int u = 0; u < 2; u++) begin
        int j;
        j = cyc - lat[u];
        if (j >= 0 && j > last_rst) begin
          for (int l = 0; l < N1; l++) begin
            if (mask_hist[j][l]) begin
              bit is_last;
              cnt_m[u][l]++;
              is_last = (cnt_m[u][l] == M3V);
              if (is_last) cnt_m[u][l] = 0;
              exp_v[u][cyc+1+l][l] = 1'b1;
              exp_d[u][cyc+1+l][l] = d;
              exp_l[u][cyc+1+l][l] = is_last;
            end
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int u = 0; u < 2; u++) begin
      logic [N1*DW-1:0] ed, od;
      logic [N1-1:0]    ev, el, ov, ol;
      for (int l = 0; l < N1; l++) begin
        ed[l*DW +: DW] = exp_d[u][cyc][l];
        ev[l]          = exp_v[u][cyc][l];
        el[l]          = exp_l[u][cyc][l];
      end
      if (u == 0) begin
        od = bus1.sys_data_D; ov = bus1.sys_valid_D; ol = bus1.row_last_D;
      end else begin
        od = bus3.sys_data_D; ov = bus3.sys_valid_D; ol = bus3.row_last_D;
      end
      chk(u == 0 ? "model_rdlat1" : "model_rdlat3",
          64'({od, ov, ol}), 64'({ed, ev, el}));
    end
  endtask

  task automatic drive(input bit r, input logic [N1-1:0] m, input logic [DW-1:0] d);
    rst             = r;
    bus1.activate_D = m;
    bus3.activate_D = m;
    bus1.rd_data_D  = d;
    bus3.rd_data_D  = d;
    model(r, m, d);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle_until(input int n);
    while (cyc < n) drive(1'b0, '0, DW'($urandom));
  endtask

  initial begin
    rst     = 1'b1;
    bus1.M3 = MW'(M3V);
    bus3.M3 = MW'(M3V);
    bus1.activate_D = '0; bus3.activate_D = '0;
    bus1.rd_data_D  = '0; bus3.rd_data_D  = '0;
    @(negedge clk);

    // Reset held 3 steps under random inputs
    for (int i = 0; i < 3; i++) drive(1'b1, N1'($urandom), DW'($urandom));
    chk("reset_outs", 64'({bus1.sys_data_D, bus1.sys_valid_D, bus1.row_last_D}), 64'd0);
    idle_until(10);

    // Single beat to lane 0
    drive(1'b0, 4'b0001, DW'($urandom));
    drive(1'b0, 4'b0000, 8'h11);
    chk("lane0_data",  64'(bus1.sys_data_D), 64'h0000_0011);
    chk("lane0_valid", 64'(bus1.sys_valid_D), 64'b0001);

    // Single beat to lane 3 emerges 3 steps later than lane 0 would
    drive(1'b0, 4'b1000, DW'($urandom));
    drive(1'b0, 4'b0000, 8'h44);
    idle_until(17);
    chk("lane3_data",  64'(bus1.sys_data_D), 64'h4400_0000);
    chk("lane3_valid", 64'(bus1.sys_valid_D), 64'b1000);

    // Four back-to-back beats to lane 1, last flag on the third
    idle_until(20);
    drive(1'b0, 4'b0010, DW'($urandom));
    drive(1'b0, 4'b0010, 8'd1);
    drive(1'b0, 4'b0010, 8'd2);
    drive(1'b0, 4'b0010, 8'd3);
    drive(1'b0, 4'b0000, 8'd4);
    chk("lane1_third_data", 64'(bus1.sys_data_D[15:8]), 64'd3);
    chk("lane1_third_last", 64'(bus1.row_last_D), 64'b0010);
    drive(1'b0, 4'b0000, DW'($urandom));
    chk("lane1_fourth_data", 64'(bus1.sys_data_D[15:8]), 64'd4);
    chk("lane1_fourth_nolast", 64'(bus1.row_last_D), 64'b0000);

    // Beat to lane 3 killed by a reset before it leaves
    idle_until(30);
    drive(1'b0, 4'b1000, DW'($urandom));
    drive(1'b0, 4'b0000, 8'h5A);
    drive(1'b0, 4'b0000, DW'($urandom));
    drive(1'b1, 4'b0000, DW'($urandom));
    chk("rst_mid_outs", 64'({bus1.sys_data_D, bus1.sys_valid_D, bus1.row_last_D}), 64'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'b0000, DW'($urandom));
      chk("rst_lane3_quiet", 64'(bus1.sys_valid_D[3]), 64'd0);
    end
    // Counter 3 must be back at 0: the third new beat carries the last flag
    drive(1'b0, 4'b1000, DW'($urandom));
    drive(1'b0, 4'b1000, 8'hC1);
    drive(1'b0, 4'b1000, 8'hC2);
    drive(1'b0, 4'b0000, 8'hC3);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'b0000, DW'($urandom));
    chk("lane3_cnt_cleared_data", 64'(bus1.sys_data_D[31:24]), 64'hC3);
    chk("lane3_cnt_cleared_last", 64'(bus1.row_last_D), 64'b1000);

    // RD_LAT=3 instance: lane 2 beat
    idle_until(60);
    drive(1'b0, 4'b0100, DW'($urandom));
    drive(1'b0, 4'b0000, DW'($urandom));
    drive(1'b0, 4'b0000, DW'($urandom));
    drive(1'b0, 4'b0000, 8'hA5);
    idle_until(66);
    chk("rdlat3_lane2_data",  64'(bus3.sys_data_D[23:16]), 64'hA5);
    chk("rdlat3_lane2_valid", 64'(bus3.sys_valid_D), 64'b0100);

    // All-zero mask for 20 steps
    for (int i = 0; i < 20; i++) drive(1'b0, 4'b0000, DW'($urandom));
    chk("idle_outs", 64'({bus3.sys_data_D, bus3.sys_valid_D, bus3.row_last_D}), 64'd0);

    // Randomized traffic: zero, one-hot and multi-hot masks, occasional reset
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [N1-1:0] m;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      m = '0;
      else if (sel < 8) m = N1'(1) << $urandom_range(0, N1 - 1);
      else              m = N1'($urandom);
      drive($urandom_range(0, 39) == 0, m, DW'($urandom));
    end
    for (int i = 0; i < 10; i++) drive(1'b0, 4'b0000, DW'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
